// File: rtl/l0_ctrl_if.sv
// Command, SRAM read-port and L0 strobe bundle between the decoder/environment
// (master) and the L0 fetch/drain sequencer (slave).
interface l0_ctrl_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [6:0]        num_vec_i;
  logic              mode_i;
  logic              array_stall_i;
  logic              l0_full_i;
  logic              l0_ready_i;
  logic              sram_cen_o;
  logic              sram_wen_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic              l0_wr_o;
  logic              l0_rd_o;
  logic              l0_version_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, base_addr_i, num_vec_i, mode_i, array_stall_i, l0_full_i, l0_ready_i,
    input  sram_cen_o, sram_wen_o, sram_addr_o, l0_wr_o, l0_rd_o, l0_version_o, busy_o, done_o
  );

  modport slave (
    input  start_i, base_addr_i, num_vec_i, mode_i, array_stall_i, l0_full_i, l0_ready_i,
    output sram_cen_o, sram_wen_o, sram_addr_o, l0_wr_o, l0_rd_o, l0_version_o, busy_o, done_o
  );
endinterface

// File: rtl/l0_ctrl.sv
// L0 input FIFO sequencer: fetches num_vec activation vectors from SRAM into L0,
// drains them into the systolic array, waits for all row FIFOs to empty, then pulses done.
module l0_ctrl #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  l0_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_EMPTY, LOAD, LOAD_TAIL, DRAIN, FLUSH, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [6:0]        num_q, num_d;
  logic [6:0]        issue_q, issue_d;
  logic [6:0]        rd_q, rd_d;
  logic              mode_q, mode_d;
  logic              wr_q;

  logic              issue;
  logic              l0_rd;
  logic [ADDR_W-1:0] sram_addr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      issue_q <= '0;
      rd_q    <= '0;
      mode_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      issue_q <= issue_d;
      rd_q    <= rd_d;
      mode_q  <= mode_d;
      // SRAM data lands one cycle after the issue and is written straight into L0
      wr_q    <= issue;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    issue_d   = issue_q;
    rd_d      = rd_q;
    mode_d    = mode_q;
    issue     = 1'b0;
    l0_rd     = 1'b0;
    sram_addr = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          base_d  = bus.base_addr_i;
          num_d   = bus.num_vec_i;
          mode_d  = bus.mode_i;
          issue_d = '0;
          rd_d    = '0;
          if (bus.num_vec_i == '0)   state_d = DONE;
          else if (bus.l0_ready_i)   state_d = LOAD;
          else                       state_d = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        if (bus.l0_ready_i) state_d = LOAD;
      end
      LOAD: begin
        sram_addr = base_q + ADDR_W'(issue_q);
        if (!bus.l0_full_i) begin
          issue   = 1'b1;
          issue_d = issue_q + 7'd1;
          if (issue_d == num_q) state_d = LOAD_TAIL;
        end
      end
      LOAD_TAIL: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.array_stall_i) begin
          l0_rd = 1'b1;
          rd_d  = rd_q + 7'd1;
          if (rd_d == num_q) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.l0_ready_i) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sram_cen_o   = ~issue;
  assign bus.sram_wen_o   = 1'b1;
  assign bus.sram_addr_o  = sram_addr;
  assign bus.l0_wr_o      = wr_q;
  assign bus.l0_rd_o      = l0_rd;
  assign bus.l0_version_o = mode_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);

endmodule

// File: tb/tb_l0_ctrl.sv
// Randomised and directed bench for l0_ctrl with a behavioural L0 occupancy model
// and a queue-based scoreboard checked by an independent monitor.
module tb_l0_ctrl;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned ROW    = 8;
  localparam int unsigned DEPTH  = 64;
  typedef logic [ADDR_W-1:0] addr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l0_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  l0_ctrl #(.ADDR_W(ADDR_W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

  logic       drv_start, drv_mode, drv_full, drv_stall, hold_ready, rnd_en;
  addr_t      drv_base;
  logic [6:0] drv_n;

  assign bus.start_i       = drv_start;
  assign bus.base_addr_i   = drv_base;
  assign bus.num_vec_i     = drv_n;
  assign bus.mode_i        = drv_mode;
  assign bus.array_stall_i = drv_stall;

  // Behavioural L0 bank: occupancy plus skew tail (last row empties ROW-1 cycles late)
  int occ = 0;
  int skew = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 0;
      skew <= 0;
    end else begin
      occ <= occ + int'(bus.l0_wr_o) - int'(bus.l0_rd_o);
      if (bus.l0_rd_o && bus.l0_version_o) skew <= ROW - 1;
      else if (skew > 0)                   skew <= skew - 1;
    end
  end
  assign bus.l0_ready_i = (occ == 0) && (skew == 0) && !hold_ready;
  assign bus.l0_full_i  = drv_full || (occ >= DEPTH);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int n_read = 0, n_wr = 0, n_rd = 0, n_done = 0;
  int t0 = 0;
  logic timed = 1'b0;
  logic exp_ver = 1'b0;
  addr_t exp_addr[$];
  int q_rcyc[$], q_wcyc[$], q_rdcyc[$], q_dcyc[$];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe
  always @(negedge clk) begin : mon
    int rel;
    if (rst_n) begin
      rel = cyc - t0 + 1;
      if (!bus.sram_cen_o) begin
        n_read++;
        chk("read_while_full", bus.l0_full_i, 0);
        chk("read_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("sram_addr", bus.sram_addr_o, exp_addr.pop_front());
        if (timed) chk("read_cycle", rel, q_rcyc.size() > 0 ? q_rcyc.pop_front() : -1);
      end
      if (bus.l0_wr_o) begin
        n_wr++;
        if (timed) chk("l0_wr_cycle", rel, q_wcyc.size() > 0 ? q_wcyc.pop_front() : -1);
      end
      if (bus.l0_rd_o) begin
        n_rd++;
        if (timed) chk("l0_rd_cycle", rel, q_rdcyc.size() > 0 ? q_rdcyc.pop_front() : -1);
      end
      if (bus.done_o) begin
        n_done++;
        if (timed) chk("done_cycle", rel, q_dcyc.size() > 0 ? q_dcyc.pop_front() : -1);
      end
      if (bus.busy_o) chk("l0_version", bus.l0_version_o, exp_ver);
    end
  end

  initial begin : randstall
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) begin
        drv_full  = ($urandom_range(0, 3) == 0);
        drv_stall = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cen"},  bus.sram_cen_o, 1);
    chk({tag, "_wen"},  bus.sram_wen_o, 1);
    chk({tag, "_addr"}, bus.sram_addr_o, 0);
    chk({tag, "_wr"},   bus.l0_wr_o, 0);
    chk({tag, "_rd"},   bus.l0_rd_o, 0);
    chk({tag, "_ver"},  bus.l0_version_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
  endtask

  task automatic push_addrs(input addr_t base, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(addr_t'(int'(base) + i));
  endtask

  task automatic run_xfer(input addr_t base, input int n, input logic mode, input logic tm,
                          input logic stall_plan, input logic hold, input logic mid_start);
    int b_read, b_wr, b_rd, b_done, fcnt, scnt;
    logic got, fdone, sdone, pulsed;
    @(posedge clk);
    #1;
    b_read = n_read; b_wr = n_wr; b_rd = n_rd; b_done = n_done;
    exp_ver = mode;
    timed = tm;
    if (!hold) push_addrs(base, n);
    if (tm) begin
      for (int i = 1; i <= n; i++) begin
        q_rcyc.push_back(i);
        q_wcyc.push_back(i + 1);
        q_rdcyc.push_back(n + 1 + i);
      end
      q_dcyc.push_back(mode ? 2 * n + 3 + (ROW - 1) : 2 * n + 3);
    end
    hold_ready = hold;
    drv_start = 1'b1; drv_base = base; drv_n = 7'(n); drv_mode = mode;
    @(posedge clk);
    #1;
    t0 = cyc;
    drv_start = 1'b0;
    drv_base = addr_t'($urandom); drv_n = 7'($urandom); drv_mode = ~mode;
    if (hold) begin
      repeat (5) @(posedge clk);
      #1;
      chk("wait_empty_busy", bus.busy_o, 1);
      chk("wait_empty_no_read", n_read - b_read, 0);
      push_addrs(base, n);
      hold_ready = 1'b0;
    end
    got = 1'b0; fdone = 1'b0; sdone = 1'b0; pulsed = 1'b0; fcnt = 0; scnt = 0;
    for (int k = 0; k < 1000 && !got; k++) begin
      if (bus.done_o) begin
        got = 1'b1;
        chk("busy_during_done", bus.busy_o, 1);
      end else begin
        if (drv_start) drv_start = 1'b0;
        if (mid_start && !pulsed && bus.l0_rd_o) begin
          pulsed = 1'b1;
          drv_start = 1'b1; drv_n = 7'd5; drv_mode = ~mode;
        end
        if (stall_plan) begin
          if (fcnt > 0) begin
            fcnt--;
            if (fcnt == 0) drv_full = 1'b0;
          end else if (!fdone && (n_read - b_read) == 3) begin
            fdone = 1'b1; fcnt = 3; drv_full = 1'b1;
          end
          if (scnt > 0) begin
            scnt--;
            if (scnt == 0) drv_stall = 1'b0;
          end else if (!sdone && (n_rd - b_rd) == 2) begin
            sdone = 1'b1; scnt = 2; drv_stall = 1'b1;
          end
        end
        @(posedge clk);
        #1;
      end
    end
    drv_start = 1'b0;
    chk("done_seen", got, 1);
    @(posedge clk);
    #1;
    chk("busy_after_done", bus.busy_o, 0);
    chk("done_one_cycle", bus.done_o, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("num_reads", n_read - b_read, n);
    chk("num_l0_wr", n_wr - b_wr, n);
    chk("num_l0_rd", n_rd - b_rd, n);
    chk("num_done",  n_done - b_done, 1);
    chk("addr_left", exp_addr.size(), 0);
    if (tm) chk("timing_left", q_rcyc.size() + q_wcyc.size() + q_rdcyc.size() + q_dcyc.size(), 0);
    q_rcyc.delete(); q_wcyc.delete(); q_rdcyc.delete(); q_dcyc.delete();
    timed = 1'b0;
  endtask

  initial begin : driver
    int b_read;
    logic ok;
    drv_start = 1'b0; drv_base = '0; drv_n = '0; drv_mode = 1'b0;
    drv_full = 1'b0; drv_stall = 1'b0; hold_ready = 1'b0; rnd_en = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_xfer(11'h010, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_xfer(11'h7FE, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_xfer(addr_t'($urandom), 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_xfer(11'h123, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_xfer(11'h055, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer(11'h300, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_xfer(11'h2A0, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a load
    @(posedge clk);
    #1;
    b_read = n_read;
    exp_ver = 1'b1;
    push_addrs(11'h400, 10);
    drv_start = 1'b1; drv_base = 11'h400; drv_n = 7'd10; drv_mode = 1'b1;
    @(posedge clk);
    #1;
    drv_start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      #1;
      ok = ((n_read - b_read) == 5);
    end
    chk("five_issues_before_reset", n_read - b_read, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_addr.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_xfer(11'h3F8, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    rnd_en = 1'b1;
    for (int t = 0; t < 12; t++)
      run_xfer(addr_t'($urandom), $urandom_range(1, DEPTH), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    rnd_en = 1'b0;
    drv_full = 1'b0;
    drv_stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
